// File: rtl/ones_count_accumulator_pkg.sv
// Shared types and constants for the frame-level ones-count accumulator.
// The state enum is shared so the top and any bound checkers agree on encodings.
package ones_count_accumulator_pkg;

   localparam int SUM_W_DEF   = 8;
   localparam int WORDS_W_DEF = 8;
   localparam int CNT_W       = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/ones_count_accumulator_sat_add.sv
// Unsigned saturating adder: clamps to all-ones on carry out and flags it.
// Adding to an already all-ones operand either carries or adds zero, so clamping is sticky.
module sat_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         sat
);

   logic [W:0] full;

   assign full = {1'b0, a} + {1'b0, b};
   assign sat  = full[W];
   assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/ones_count_accumulator.sv
// Accumulates per-beat ones counts into a saturating per-frame total and beat count.
// Handshake: a beat transfers on a rising edge with in_valid && in_ready; the result transfers with out_valid && out_ready.
module ones_count_accumulator
   import ones_count_accumulator_pkg::*;
#(
   parameter int SUM_W   = SUM_W_DEF,
   parameter int WORDS_W = WORDS_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CNT_W-1:0]   in_cnt,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SUM_W-1:0]   out_sum,
   output logic [WORDS_W-1:0] out_words,
   output logic               out_ovf
);

   state_t             state, state_nxt;
   logic [SUM_W-1:0]   sum_q, sum_nxt, sum_add, cnt_ext;
   logic [WORDS_W-1:0] words_q, words_nxt, words_add;
   logic               ovf_q, ovf_nxt;
   logic               sum_sat, words_sat;

   assign cnt_ext = SUM_W'(in_cnt);

   sat_add #(.W(SUM_W)) u_sum_add (
      .a   (sum_q),
      .b   (cnt_ext),
      .sum (sum_add),
      .sat (sum_sat)
   );

   sat_add #(.W(WORDS_W)) u_words_add (
      .a   (words_q),
      .b   (WORDS_W'(1)),
      .sum (words_add),
      .sat (words_sat)
   );

   // Handshake outputs come from the state register alone, never from in_valid/out_ready.
   assign in_ready  = (state != DONE);
   assign out_valid = (state == DONE);
   assign out_sum   = sum_q;
   assign out_words = words_q;
   assign out_ovf   = ovf_q;

   always_comb begin
      state_nxt = state;
      sum_nxt   = sum_q;
      words_nxt = words_q;
      ovf_nxt   = ovf_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sum_nxt   = cnt_ext;
               words_nxt = WORDS_W'(1);
               ovf_nxt   = 1'b0;
               state_nxt = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               sum_nxt   = sum_add;
               words_nxt = words_add;
               ovf_nxt   = ovf_q | sum_sat | words_sat;
               if (in_last) state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               sum_nxt   = '0;
               words_nxt = '0;
               ovf_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sum_q   <= '0;
         words_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         sum_q   <= sum_nxt;
         words_q <= words_nxt;
         ovf_q   <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Bench for ones_count_accumulator: three width variants share one stimulus stream,
// frame results are predicted from a table and checked by a queue-based scoreboard.
module tb_ones_count_accumulator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_cnt = 2'd0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_ready, out_valid, out_ovf;
   logic [7:0] out_sum, out_words;
   logic       s4_in_ready, s4_out_valid, s4_ovf;
   logic [3:0] s4_sum;
   logic [7:0] s4_words;
   logic       w2_in_ready, w2_out_valid, w2_ovf;
   logic [7:0] w2_sum;
   logic [1:0] w2_words;

   int checks = 0;
   int failures = 0;

   logic [16:0] exp_q0[$];
   logic [16:0] exp_q1[$];
   logic [16:0] exp_q2[$];

   typedef struct {
      int          len;
      int          gap;
      logic [1:0]  cnts [8];
      logic [16:0] exp_main;
      logic [16:0] exp_s4;
      logic [16:0] exp_w2;
   } frame_t;

   frame_t frames [6];

   ones_count_accumulator u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_cnt(in_cnt), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_words(out_words), .out_ovf(out_ovf)
   );

   ones_count_accumulator #(.SUM_W(4), .WORDS_W(8)) u_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s4_in_ready),
      .in_cnt(in_cnt), .in_last(in_last), .out_valid(s4_out_valid), .out_ready(out_ready),
      .out_sum(s4_sum), .out_words(s4_words), .out_ovf(s4_ovf)
   );

   ones_count_accumulator #(.SUM_W(8), .WORDS_W(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w2_in_ready),
      .in_cnt(in_cnt), .in_last(in_last), .out_valid(w2_out_valid), .out_ready(out_ready),
      .out_sum(w2_sum), .out_words(w2_words), .out_ovf(w2_ovf)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [16:0] mk(int sum, int words, int ovf);
      return {ovf[0], words[7:0], sum[7:0]};
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // scoreboard: pop one expected result per transferred frame result
   always @(negedge clk) begin
      if (rst_n && out_ready) begin
         if (out_valid) begin
            if (exp_q0.size() == 0) begin
               checks++; failures++;
               $display("FAIL main_result got=%0h exp=none", {out_ovf, out_words, out_sum});
            end else check("main_result", {out_ovf, out_words, out_sum}, exp_q0.pop_front());
         end
         if (s4_out_valid) begin
            if (exp_q1.size() == 0) begin
               checks++; failures++;
               $display("FAIL s4_result got=%0h exp=none", {s4_ovf, s4_words, 4'h0, s4_sum});
            end else check("s4_result", {s4_ovf, s4_words, 4'h0, s4_sum}, exp_q1.pop_front());
         end
         if (w2_out_valid) begin
            if (exp_q2.size() == 0) begin
               checks++; failures++;
               $display("FAIL w2_result got=%0h exp=none", {w2_ovf, 6'h0, w2_words, w2_sum});
            end else check("w2_result", {w2_ovf, 6'h0, w2_words, w2_sum}, exp_q2.pop_front());
         end
      end
   end

   // driver: present one beat and hold it until all instances accept it
   task automatic drive_beat(logic [1:0] cnt, logic last, output int waits);
      logic ok;
      in_valid = 1'b1;
      in_cnt   = cnt;
      in_last  = last;
      waits    = 0;
      forever begin
         @(negedge clk);
         ok = in_ready & s4_in_ready & w2_in_ready;
         @(posedge clk); #1;
         if (ok) break;
         waits++;
         if (waits > 50) begin
            checks++; failures++;
            $display("FAIL beat_accept got=stalled exp=accepted");
            break;
         end
      end
      in_valid = 1'b0;
      in_cnt   = 2'd0;
      in_last  = 1'b0;
   endtask

   task automatic push_exp(int idx);
      exp_q0.push_back(frames[idx].exp_main);
      exp_q1.push_back(frames[idx].exp_s4);
      exp_q2.push_back(frames[idx].exp_w2);
   endtask

   // sends a whole frame; with hold=1 the result is left pending in DONE
   task automatic send_frame(int idx, bit hold);
      int waits;
      for (int b = 0; b < frames[idx].len; b++) begin
         bit last;
         last = (b == frames[idx].len - 1);
         if (last) push_exp(idx);
         drive_beat(frames[idx].cnts[b], last, waits);
         if (!last) begin
            for (int g = 0; g < frames[idx].gap; g++) begin
               @(negedge clk);
               check("gap_in_ready", in_ready, 1);
               check("gap_out_valid", out_valid, 0);
               @(posedge clk); #1;
            end
         end
      end
      @(negedge clk);
      check("latency_out_valid", out_valid, 1);
      @(posedge clk); #1;
      if (!hold) begin
         @(negedge clk);
         check("one_cycle_out_valid", out_valid, 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int waits;
      frames[0] = '{len: 4, gap: 0, cnts: '{2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0},
                    exp_main: mk(6, 4, 0), exp_s4: mk(6, 4, 0), exp_w2: mk(6, 3, 1)};
      frames[1] = '{len: 6, gap: 0, cnts: '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0},
                    exp_main: mk(18, 6, 0), exp_s4: mk(15, 6, 1), exp_w2: mk(18, 3, 1)};
      frames[2] = '{len: 5, gap: 0, cnts: '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    exp_main: mk(0, 5, 0), exp_s4: mk(0, 5, 0), exp_w2: mk(0, 3, 1)};
      frames[3] = '{len: 1, gap: 0, cnts: '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    exp_main: mk(1, 1, 0), exp_s4: mk(1, 1, 0), exp_w2: mk(1, 1, 0)};
      frames[4] = '{len: 2, gap: 3, cnts: '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    exp_main: mk(3, 2, 0), exp_s4: mk(3, 2, 0), exp_w2: mk(3, 2, 0)};
      frames[5] = '{len: 8, gap: 0, cnts: '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd1},
                    exp_main: mk(15, 8, 0), exp_s4: mk(15, 8, 0), exp_w2: mk(15, 3, 1)};

      // reset state
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_words", out_words, 0);
      check("rst_out_ovf", out_ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic frame, then the same frame with backpressure
      send_frame(0, 1'b0);
      out_ready = 1'b0;
      send_frame(0, 1'b1);
      in_valid = 1'b1; in_cnt = 2'd1; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_out_sum", out_sum, 6);
         check("stall_out_words", out_words, 4);
         check("stall_out_ovf", out_ovf, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      push_exp(3);
      drive_beat(2'd1, 1'b1, waits);
      check("stall_release_waits", waits, 1);
      @(negedge clk);
      check("after_stall_out_valid", out_valid, 1);
      @(posedge clk); #1;

      // table of frames
      for (int f = 0; f < 6; f++) send_frame(f, 1'b0);

      // asynchronous reset in the middle of a frame
      drive_beat(2'd3, 1'b0, waits);
      drive_beat(2'd2, 1'b0, waits);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_sum", out_sum, 0);
      check("midrst_out_words", out_words, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(3, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("main_queue_empty", exp_q0.size(), 0);
      check("s4_queue_empty", exp_q1.size(), 0);
      check("w2_queue_empty", exp_q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
